// File: rtl/dmem_readback_streamer.sv
// Walks a base/count window of data memory through its synchronous
// read port and streams each word with its address on a valid/ready port.
module dmem_readback_streamer #(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_count,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        state;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] remaining;

    logic          inflight;
    logic [AW-1:0] inf_addr;
    logic          inf_last;

    logic          sk_valid;
    logic [DW-1:0] sk_data;
    logic [AW-1:0] sk_addr;
    logic          sk_last;

    logic          pop;
    logic          issue;
    logic [1:0]    occ;

    assign pop = out_valid && out_ready;

    // A pop this cycle frees a slot before the issued read can land,
    // which is what lets the stream sustain one word per cycle.
    assign occ = {1'b0, out_valid} + {1'b0, sk_valid}
               + {1'b0, inflight} - {1'b0, pop};

    assign issue = (state == RUN) && (remaining != '0)
                && (occ < 2'd2);

    assign mem_re   = issue;
    assign mem_addr = issue ? rd_ptr : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            inf_addr  <= '0;
            inf_last  <= 1'b0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            sk_addr   <= '0;
            sk_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                inf_addr  <= rd_ptr;
                inf_last  <= (remaining == CW'(1));
                rd_ptr    <= rd_ptr + AW'(1);
                remaining <= remaining - CW'(1);
            end

            if (pop) begin
                if (sk_valid) begin
                    out_data <= sk_data;
                    out_addr <= sk_addr;
                    out_last <= sk_last;
                    sk_valid <= inflight;
                    if (inflight) begin
                        sk_data <= mem_rdata;
                        sk_addr <= inf_addr;
                        sk_last <= inf_last;
                    end
                end else begin
                    out_valid <= inflight;
                    if (inflight) begin
                        out_data <= mem_rdata;
                        out_addr <= inf_addr;
                        out_last <= inf_last;
                    end
                end
            end else if (inflight) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= mem_rdata;
                    out_addr  <= inf_addr;
                    out_last  <= inf_last;
                end else begin
                    sk_valid <= 1'b1;
                    sk_data  <= mem_rdata;
                    sk_addr  <= inf_addr;
                    sk_last  <= inf_last;
                end
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr    <= base_addr;
                        remaining <= word_count;
                        if (word_count == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && out_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_readback_streamer.sv
// Randomized scoreboard bench: a queue-based burst model feeds expected
// words; a negedge monitor checks stream, timing and handshake rules.
module tb_dmem_readback_streamer;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    dmem_readback_streamer #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } exp_t;

    exp_t sbq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_due = -1;
    int valid_due = -1;
    int done_cnt = 0;
    int last_done_cyc = -1;
    int issued = 0;
    int popped = 0;
    int acc_cyc = 0;
    bit rdy_rand = 1'b0;
    bit rdy_hold = 1'b1;

    logic          stall = 1'b0;
    logic [DW-1:0] h_d;
    logic [AW-1:0] h_a;
    logic          h_l;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            issued = 0;
            popped = 0;
            stall  = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(h_d));
                chk("hold_addr", 64'(out_addr), 64'(h_a));
                chk("hold_last", 64'(out_last), 64'(h_l));
            end
            if (out_valid && out_ready) begin
                popped++;
                chk("word_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_addr", 64'(out_addr), 64'(e.a));
                    chk("out_last", 64'(out_last), 64'(e.l));
                    if (e.l) done_due = cyc + 1;
                end
            end
            stall = out_valid && !out_ready;
            h_d = out_data;
            h_a = out_addr;
            h_l = out_last;
            if (mem_re) begin
                issued++;
                chk("mem_re_busy", 64'(busy), 64'd1);
                chk("outstanding", 64'((issued - popped) <= 2), 64'd1);
            end
            if (cyc == valid_due)
                chk("first_valid", 64'(out_valid), 64'd1);
            if (done || cyc == done_due)
                chk("done", 64'(done), 64'(cyc == done_due));
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
    endtask

    task automatic do_start(input logic [AW-1:0] b,
                            input int n, input bit accept);
        start      = 1'b1;
        base_addr  = b;
        word_count = CW'(n);
        step();
        start = 1'b0;
        if (accept) begin
            acc_cyc = cyc;
            if (n == 0) begin
                done_due = cyc;
                chk("busy_zero", 64'(busy), 64'd0);
            end else begin
                valid_due = cyc + 2;
                chk("busy_set", 64'(busy), 64'd1);
                for (int i = 0; i < n; i++) begin
                    exp_t e;
                    logic [AW-1:0] ad;
                    ad  = b + AW'(i);
                    e.d = mem[ad];
                    e.a = ad;
                    e.l = (i == n - 1);
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_done();
        int n0;
        int k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < 3000) begin
            step();
            k++;
        end
        chk("done_timeout", 64'(done_cnt != n0), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_addr"}, 64'(out_addr), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_re"}, 64'(mem_re), 64'd0);
        chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    endtask

    initial begin
        int a0;
        int p0;
        int k;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + i;
        mem[8'hFF] = 32'd1;
        mem[8'h00] = 32'd2;
        mem[8'h01] = 32'd3;
        step();
        step();
        chk_zero("reset");
        reset = 1'b0;
        step();

        do_start(8'h10, 4, 1'b1);
        a0 = acc_cyc;
        wait_done();
        chk("basic_done_cyc", 64'(last_done_cyc), 64'(a0 + 6));

        rdy_hold = 1'b0;
        do_start(8'h10, 4, 1'b1);
        repeat (6) step();
        chk("bp_data", 64'(out_data), 64'hA0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        rdy_hold = 1'b1;
        wait_done();

        do_start(8'hFF, 3, 1'b1);
        wait_done();

        do_start(8'h33, 0, 1'b1);
        wait_done();

        do_start(8'h10, 4, 1'b1);
        step();
        step();
        do_start(8'h40, 5, 1'b0);
        wait_done();
        repeat (4) step();

        do_start(8'h20, 8, 1'b1);
        p0 = popped;
        k  = 0;
        while (popped < p0 + 2 && k < 100) begin
            step();
            k++;
        end
        chk("rst_two_words", 64'(popped >= p0 + 2), 64'd1);
        reset = 1'b1;
        step();
        chk_zero("midrst");
        step();
        reset = 1'b0;
        done_due  = -1;
        valid_due = -1;
        step();
        do_start(8'h80, 5, 1'b1);
        wait_done();

        rdy_rand = 1'b1;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            do_start(AW'($urandom), $urandom_range(1, 24), 1'b1);
            wait_done();
        end
        do_start(AW'($urandom), 256, 1'b1);
        wait_done();
        rdy_rand = 1'b0;
        repeat (3) step();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
